search_window_feeder: RTL and testbench

Reads a rectangular search window from the reference-frame pixel memory in raster order and drives the pixel delay-line chain of the full-search PE array (the `d`/`en` side of the shift chain). Generates memory addresses, absorbs the one-cycle memory read latency, and honours a stall from the PE array without losing or duplicating pixels. One instance per search-window port.

---
 rtl/search_window_feeder.sv | 149 ++++++++++++++
 tb/tb_search_window_feeder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/search_window_feeder.sv
// Streams a rectangular search window from pixel memory into the PE-array delay-line chain.
// Define SEARCH_WINDOW_FEEDER_FLUSH_EN to append FLUSH_LEN zero pixels after each window.
module search_window_feeder #(
  parameter int DWIDTH    = 8,
  parameter int AWIDTH    = 12,
  parameter int SW_W      = 31,
  parameter int SW_H      = 31,
  parameter int FRAME_W   = 64,
  parameter int FLUSH_LEN = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [AWIDTH-1:0] base_addr_i,
  input  logic              stall_i,
  output logic              mem_rd_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  input  logic [DWIDTH-1:0] mem_data_i,
  output logic              en_out_o,
  output logic [DWIDTH-1:0] d_out_o,
  output logic              busy_o,
  output logic              done_o
);

  // state   | meaning
  // IDLE    | waiting for start
  // FETCH   | issuing reads in raster order
  // DRAIN   | waiting for the last read and the skid to empty
  // FLUSH   | emitting zero pixels (flush build only)
  // DONE    | one-cycle done pulse
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
`ifdef SEARCH_WINDOW_FEEDER_FLUSH_EN
    S_FLUSH,
`endif
    S_DONE
  } state_t;

  localparam int XW = $clog2(SW_W + 1);
  localparam int YW = $clog2(SW_H + 1);

  state_t              state_q;
  logic [AWIDTH-1:0]   row_q, addr_q;
  logic [XW-1:0]       x_q;
  logic [YW-1:0]       y_q;
  logic                pend_q, skid_vld_q;
  logic [DWIDTH-1:0]   skid_q, d_q;
  logic                rd, emit_mem, emit_skid, emit_fl;
  logic [AWIDTH-1:0]   next_row;

`ifdef SEARCH_WINDOW_FEEDER_FLUSH_EN
  localparam int FW = $clog2(FLUSH_LEN + 1);
  logic [FW-1:0] flush_q;
  assign emit_fl = (state_q == S_FLUSH) && !stall_i;
`else
  assign emit_fl = 1'b0;
`endif

  // Read/emit strobes depend on this cycle's stall, so they are decoded rather than flopped.
  assign rd        = (state_q == S_FETCH) && !stall_i && !skid_vld_q;
  assign emit_mem  = pend_q && !stall_i;
  assign emit_skid = skid_vld_q && !stall_i;
  assign next_row  = row_q + AWIDTH'(FRAME_W);

  assign mem_rd_o   = rd;
  assign mem_addr_o = addr_q;
  assign en_out_o   = emit_mem || emit_skid || emit_fl;
  assign d_out_o    = emit_mem  ? mem_data_i :
                      emit_skid ? skid_q     :
                      emit_fl   ? '0         : d_q;
  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      addr_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      pend_q     <= 1'b0;
      skid_vld_q <= 1'b0;
      skid_q     <= '0;
      d_q        <= '0;
`ifdef SEARCH_WINDOW_FEEDER_FLUSH_EN
      flush_q    <= '0;
`endif
    end else begin
      pend_q <= rd;
      // A skid fill never coincides with a pending read: reads stop while stalled or skid full.
      if (pend_q && stall_i) begin
        skid_q     <= mem_data_i;
        skid_vld_q <= 1'b1;
      end else if (emit_skid) begin
        skid_vld_q <= 1'b0;
      end
      if (en_out_o) d_q <= d_out_o;

      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            row_q   <= base_addr_i;
            addr_q  <= base_addr_i;
            x_q     <= '0;
            y_q     <= '0;
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (rd) begin
            if (x_q == XW'(SW_W - 1)) begin
              x_q    <= '0;
              y_q    <= y_q + YW'(1);
              row_q  <= next_row;
              addr_q <= next_row;
              if (y_q == YW'(SW_H - 1)) state_q <= S_DRAIN;
            end else begin
              x_q    <= x_q + XW'(1);
              addr_q <= addr_q + AWIDTH'(1);
            end
          end
        end
        S_DRAIN: begin
          if (!pend_q && !skid_vld_q) begin
`ifdef SEARCH_WINDOW_FEEDER_FLUSH_EN
            flush_q <= FW'(FLUSH_LEN);
            state_q <= S_FLUSH;
`else
            state_q <= S_DONE;
`endif
          end
        end
`ifdef SEARCH_WINDOW_FEEDER_FLUSH_EN
        S_FLUSH: begin
          if (emit_fl) begin
            flush_q <= flush_q - FW'(1);
            if (flush_q == FW'(1)) state_q <= S_DONE;
          end
        end
`endif
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_search_window_feeder.sv
// Scoreboard bench for search_window_feeder: 4x3 window, stride 8, directed scenarios.
module tb_search_window_feeder;
  localparam int DW = 8, AW = 12, SWW = 4, SWH = 3, FW = 8, FL = 16;
`ifdef SEARCH_WINDOW_FEEDER_FLUSH_EN
  localparam int EXTRA = FL;
`else
  localparam int EXTRA = 0;
`endif

  logic          clk = 0, rst_n = 0, start = 0, stall = 0;
  logic [AW-1:0] base = '0, mem_addr;
  logic [DW-1:0] mem_data = '0, d_out;
  logic          mem_rd, en_out, busy, done;

  search_window_feeder #(.DWIDTH(DW), .AWIDTH(AW), .SW_W(SWW), .SW_H(SWH),
                         .FRAME_W(FW), .FLUSH_LEN(FL)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .base_addr_i(base), .stall_i(stall),
    .mem_rd_o(mem_rd), .mem_addr_o(mem_addr), .mem_data_i(mem_data),
    .en_out_o(en_out), .d_out_o(d_out), .busy_o(busy), .done_o(done));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] pix(input logic [AW-1:0] a);
    return DW'(a * 7 + 3);
  endfunction

  // memory model: one-cycle read latency
  always @(posedge clk) if (mem_rd) mem_data <= pix(mem_addr);

  int checks = 0, fails = 0;
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [AW-1:0] exp_addr[$];
  logic [DW-1:0] exp_pix[$];
  int pix_cnt = 0, first_en = -1, done_cyc = -1, done_cnt = 0, stall_en = 0;

  task automatic push_window(input logic [AW-1:0] b);
    logic [AW-1:0] a;
    for (int y = 0; y < SWH; y++)
      for (int x = 0; x < SWW; x++) begin
        a = AW'(b + y * FW + x);
        exp_addr.push_back(a);
        exp_pix.push_back(pix(a));
      end
    for (int i = 0; i < EXTRA; i++) exp_pix.push_back('0);
  endtask

  always @(negedge clk) if (rst_n) begin
    if (mem_rd) begin
      if (exp_addr.size() == 0) check("addr_unexpected", 1, 0);
      else check("mem_addr", int'(mem_addr), int'(exp_addr.pop_front()));
    end
    if (en_out) begin
      if (stall) stall_en++;
      if (exp_pix.size() == 0) check("pixel_unexpected", 1, 0);
      else check("d_out", int'(d_out), int'(exp_pix.pop_front()));
      pix_cnt++;
      if (first_en < 0) first_en = cyc;
    end
    if (done) begin
      done_cyc = cyc;
      done_cnt++;
    end
  end

  task automatic do_start(input logic [AW-1:0] b, output int t);
    pix_cnt = 0; first_en = -1; done_cyc = -1; stall_en = 0;
    @(posedge clk); #1;
    start = 1; base = b; t = cyc;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_done(input int prev);
    int n = 0;
    while (done_cnt == prev && n < 300) begin
      @(posedge clk); n++;
    end
    if (done_cnt == prev) check("done_timeout", 0, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("busy_after_done", int'(busy), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_mem_rd"}, int'(mem_rd), 0);
    check({tag, "_mem_addr"}, int'(mem_addr), 0);
    check({tag, "_en_out"}, int'(en_out), 0);
    check({tag, "_d_out"}, int'(d_out), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    int t, dc;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1; rst_n = 1;

    // 1: unstalled window at base 10
    push_window(12'd10);
    dc = done_cnt;
    do_start(12'd10, t);
    @(negedge clk);
    check("busy_t+1", int'(busy), 1);
    wait_done(dc);
    check("first_en_lat", first_en - t, 2);
    check("done_lat", done_cyc - t, 15 + EXTRA);
    check("pix_cnt", pix_cnt, SWW * SWH + EXTRA);
    check("queue_empty", exp_pix.size() + exp_addr.size(), 0);

    // 2: same window, stall in cycles t+3..t+5
    push_window(12'd10);
    dc = done_cnt;
    do_start(12'd10, t);
    @(posedge clk); #1;
    @(posedge clk); #1; stall = 1;
    repeat (3) begin @(posedge clk); #1; end
    stall = 0;
    wait_done(dc);
    check("stall_en_overlap", stall_en, 0);
    check("stall_pix_cnt", pix_cnt, SWW * SWH + EXTRA);
    check("stall_done_lat", done_cyc - t, 19 + EXTRA);
    check("stall_queue_empty", exp_pix.size() + exp_addr.size(), 0);

    // 3: address wraparound from 4094
    push_window(12'd4094);
    dc = done_cnt;
    do_start(12'd4094, t);
    wait_done(dc);
    check("wrap_pix_cnt", pix_cnt, SWW * SWH + EXTRA);

    // 4: start pulsed while busy is ignored
    push_window(12'd40);
    dc = done_cnt;
    do_start(12'd40, t);
    @(posedge clk); #1; @(posedge clk); #1;
    start = 1; base = 12'd100;
    @(posedge clk); #1; start = 0;
    wait_done(dc);
    check("busy_start_pix_cnt", pix_cnt, SWW * SWH + EXTRA);
    check("busy_start_done_cnt", done_cnt - dc, 1);
    check("busy_start_queue", exp_pix.size() + exp_addr.size(), 0);

    // 5: reset during 5th pixel, then fresh window at base 0
    push_window(12'd20);
    do_start(12'd20, t);
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 0;
    exp_addr.delete(); exp_pix.delete();
    @(negedge clk);
    check_outputs_zero("midreset");
    @(posedge clk); #1;
    @(negedge clk);
    check_outputs_zero("midreset_next");
    @(posedge clk); #1; rst_n = 1;
    push_window(12'd0);
    dc = done_cnt;
    do_start(12'd0, t);
    wait_done(dc);
    check("post_reset_first_en", first_en - t, 2);
    check("post_reset_pix_cnt", pix_cnt, SWW * SWH + EXTRA);
    check("post_reset_queue", exp_pix.size() + exp_addr.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
